regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//   Sole writer of the register-file write port (WE3/AD3/WD3). Merges single-cycle ALU
//   results with long-latency (load/multi-cycle) results buffered in a FIFO, issuing at
//   most one register write per cycle. Keeps a busy scoreboard of rd targets with
//   long-latency results still outstanding, used by decode to stall.
// PARAMETERS
//   ADDRESS_WIDTH  5   register address width; 2**ADDRESS_WIDTH registers
//   DATA_WIDTH     32  register data width
//   FIFO_DEPTH     4   long-latency result FIFO entries; power of 2, >= 2
// PORTS
//   clk         in   1                        clock, all state on posedge
//   rst_n       in   1                        asynchronous active-low reset
//   alu_valid   in   1                        ALU result valid this cycle; no backpressure
//   alu_rd      in   ADDRESS_WIDTH            ALU destination register
//   alu_data    in   DATA_WIDTH               ALU result
//   lsu_valid   in   1                        long-latency result offered
//   lsu_ready   out  1                        FIFO can accept; push on lsu_valid&&lsu_ready
//   lsu_rd      in   ADDRESS_WIDTH            long-latency destination register
//   lsu_data    in   DATA_WIDTH               long-latency result
//   iss_valid   in   1                        long-latency op issued this cycle
//   iss_rd      in   ADDRESS_WIDTH            its destination; marks busy
//   busy        out  2**ADDRESS_WIDTH         scoreboard, bit i = reg i pending
//   fifo_count  out  $clog2(FIFO_DEPTH+1)     entries in FIFO
//   WE3         out  1                        register-file write enable (registered)
//   AD3         out  ADDRESS_WIDTH            register-file write address (registered)
//   WD3         out  DATA_WIDTH               register-file write data (registered)
// BEHAVIOUR
//   - Reset (async, rst_n=0): WE3=0, AD3=0, WD3=0, FIFO emptied (contents discarded),
//     fifo_count=0, busy=0, lsu_ready=1. Reset mid-operation drops all pending results.
//   - Per-cycle select (sampled at posedge, loads WE3/AD3/WD3):
//     1. alu_valid && alu_rd!=0 -> WE3<=1, AD3<=alu_rd, WD3<=alu_data; FIFO holds.
//     2. else FIFO non-empty -> pop head; WE3<=(head.rd!=0), AD3<=head.rd, WD3<=head.data.
//     3. else WE3<=0; AD3/WD3 hold previous value.
//   - ALU priority is absolute; an ALU write with rd=0 is dropped and does not block a pop.
//   - Latency: ALU result at edge N -> WE3 high in cycle N+1 -> regfile committed at N+2.
//     LSU result pushed at edge N with FIFO empty and no ALU -> same timing.
//   - FIFO: in-order, 1 push + 1 pop per cycle. lsu_ready = (fifo_count < FIFO_DEPTH),
//     combinational from count only; when full, no push even if a pop happens that cycle.
//     Pointers wrap modulo FIFO_DEPTH. Push into empty FIFO is not popped same edge.
//   - Scoreboard: iss_valid && iss_rd!=0 sets busy[iss_rd] at the edge. busy[AD3] clears
//     at the edge where WE3=1 and the write came from the FIFO (regfile commits same edge).
//     ALU writes never clear busy (WAW ordering is decode's responsibility).
//     Set and clear of same register on same edge -> set wins. busy[0] is constant 0.
//   - Push and pop of FIFO on same edge: fifo_count unchanged.
// TESTING
//   1. Assert rst_n=0 mid-traffic -> immediately WE3=0, AD3=0, WD3=0, busy=0, fifo_count=0,
//      lsu_ready=1; no write after release until new input.
//   2. alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle at edge N -> cycle N+1
//      WE3=1, AD3=5, WD3=0xDEADBEEF; cycle N+2 WE3=0.
//   3. iss rd=7; alu_valid held 3 cycles (rd=3); push lsu rd=7 data=0x11 during first ALU
//      cycle -> three writes to x3, then WE3=1/AD3=7/WD3=0x11; busy[7] falls one cycle later.
//   4. Hold alu_valid, push 4 LSU entries rd=1..4 -> fifo_count=4, lsu_ready=0, 5th offer
//      stalls; drop alu_valid -> writes x1,x2,x3,x4 on consecutive cycles, then 5th accepted.
//   5. FIFO head rd=9 pops while iss_valid rd=9 same edge -> busy[9] stays 1; iss rd=0 ->
//      busy[0]=0; alu_rd=0 with FIFO non-empty -> head popped that cycle.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Owns the register-file write port (WE3/AD3/WD3). Single-cycle ALU results
//   take absolute priority; long-latency results wait in a small in-order FIFO
//   and drain whenever the ALU slot is free. A busy scoreboard tracks rd
//   targets whose long-latency result has not yet been committed.
module regfile_writeback #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]           alu_rd,
  input  logic [DATA_WIDTH-1:0]              alu_data,
  input  logic                               lsu_valid,
  output logic                               lsu_ready,
  input  logic [ADDRESS_WIDTH-1:0]           lsu_rd,
  input  logic [DATA_WIDTH-1:0]              lsu_data,
  input  logic                               iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]           iss_rd,
  output logic [(2**ADDRESS_WIDTH)-1:0]      busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               WE3,
  output logic [ADDRESS_WIDTH-1:0]           AD3,
  output logic [DATA_WIDTH-1:0]              WD3
);

  localparam int NUM_REGS = 2**ADDRESS_WIDTH;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH+1);

  localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]         PTR_ONE  = PTR_W'(1);
  localparam logic [ADDRESS_WIDTH-1:0] RD_ZERO  = '0;

  // FIFO storage and bookkeeping
  logic [ADDRESS_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q,  count_d;

  // Write-port registers; from_fifo_q remembers the source of the current write
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
  logic                     from_fifo_q, from_fifo_d;

  // Scoreboard
  logic [NUM_REGS-1:0]      busy_q, busy_d;

  logic                     push_s;
  logic                     pop_s;
  logic                     alu_take_s;
  logic [ADDRESS_WIDTH-1:0] head_rd_s;
  logic [DATA_WIDTH-1:0]    head_data_s;

  // Ready depends on the registered count only, so a full FIFO refuses a push
  // even when it pops on the same edge.
  assign lsu_ready   = (count_q < CNT_FULL);
  assign push_s      = lsu_valid && lsu_ready;
  // An ALU result targeting x0 is discarded and leaves the slot free for a pop.
  assign alu_take_s  = alu_valid && (alu_rd != RD_ZERO);
  // Uses the pre-edge count, so an entry pushed into an empty FIFO waits a cycle.
  assign pop_s       = !alu_take_s && (count_q != '0);
  assign head_rd_s   = rd_mem_q[rd_ptr_q];
  assign head_data_s = data_mem_q[rd_ptr_q];

  assign fifo_count  = count_q;
  assign busy        = busy_q;
  assign WE3         = we3_q;
  assign AD3         = ad3_q;
  assign WD3         = wd3_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Write-port select: ALU first, then FIFO head, otherwise idle with AD3/WD3 held
  always_comb begin
    we3_d       = 1'b0;
    ad3_d       = ad3_q;
    wd3_d       = wd3_q;
    from_fifo_d = 1'b0;
    if (alu_take_s) begin
      we3_d       = 1'b1;
      ad3_d       = alu_rd;
      wd3_d       = alu_data;
      from_fifo_d = 1'b0;
    end else if (pop_s) begin
      we3_d       = (head_rd_s != RD_ZERO);
      ad3_d       = head_rd_s;
      wd3_d       = head_data_s;
      from_fifo_d = 1'b1;
    end else begin
      we3_d       = 1'b0;
      ad3_d       = ad3_q;
      wd3_d       = wd3_q;
      from_fifo_d = 1'b0;
    end
  end

  // Scoreboard next-state: a FIFO write commits (clears), a new issue sets; set wins
  always_comb begin
    busy_d = busy_q;
    if (we3_q && from_fifo_q) begin
      busy_d[ad3_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (iss_valid && (iss_rd != RD_ZERO)) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // FIFO entry storage, written at the tail on every accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push_s) begin
      rd_mem_q[wr_ptr_q]   <= lsu_rd;
      data_mem_q[wr_ptr_q] <= lsu_data;
    end else begin
      rd_mem_q[wr_ptr_q]   <= rd_mem_q[wr_ptr_q];
      data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
    end
  end

  // State registers: FIFO control, write port and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      we3_q       <= 1'b0;
      ad3_q       <= '0;
      wd3_q       <= '0;
      from_fifo_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      we3_q       <= we3_d;
      ad3_q       <= ad3_d;
      wd3_q       <= wd3_d;
      from_fifo_q <= from_fifo_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_regfile_writeback;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [(2**AW)-1:0]          busy;
  logic [$clog2(DEPTH+1)-1:0]  fifo_count;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  regfile_writeback #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy(busy), .fifo_count(fifo_count),
    .WE3(WE3), .AD3(AD3), .WD3(WD3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: pending long-latency results as a queue, scoreboard as a bit vector
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_fifo[$];
  logic [31:0]   m_busy      = '0;
  logic          m_we        = 1'b0;
  logic [AW-1:0] m_ad        = '0;
  logic [DW-1:0] m_wd        = '0;
  logic          m_from_fifo = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_busy      = '0;
    m_we        = 1'b0;
    m_ad        = '0;
    m_wd        = '0;
    m_from_fifo = 1'b0;
  endtask

  // What one clock edge must do, from the inputs present before the edge
  task automatic model_edge();
    int   old_size;
    ent_t e;
    ent_t n;
    old_size = m_fifo.size();
    if (m_we && m_from_fifo) m_busy[m_ad] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (alu_valid && alu_rd != 5'd0) begin
      m_we = 1'b1; m_ad = alu_rd; m_wd = alu_data; m_from_fifo = 1'b0;
    end else if (old_size > 0) begin
      e = m_fifo.pop_front();
      m_we = (e.rd != 5'd0); m_ad = e.rd; m_wd = e.data; m_from_fifo = 1'b1;
    end else begin
      m_we = 1'b0; m_from_fifo = 1'b0;
    end
    if (lsu_valid && old_size < DEPTH) begin
      n.rd = lsu_rd; n.data = lsu_data;
      m_fifo.push_back(n);
    end
  endtask

  // Advance one clock; the model follows the edge, then settle 1 time unit
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic rand_inputs();
    alu_valid = ($urandom_range(0, 99) < 40);
    alu_rd    = AW'($urandom_range(0, 31));
    alu_data  = $urandom;
    lsu_valid = ($urandom_range(0, 99) < 50);
    lsu_rd    = AW'($urandom_range(0, 31));
    lsu_data  = $urandom;
    iss_valid = ($urandom_range(0, 99) < 30);
    iss_rd    = AW'($urandom_range(0, 31));
  endtask

  // Per-cycle comparison of every output against the model, mid-cycle
  always @(negedge clk) begin
    chk("we3", WE3, m_we);
    chk("ad3", AD3, m_ad);
    chk("wd3", WD3, m_wd);
    chk("busy", busy, m_busy);
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("lsu_ready", lsu_ready, (m_fifo.size() < DEPTH));
  end

  initial begin
    rst_n = 1'b0;
    alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0; iss_rd = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_we3", WE3, 1'b0);
    chk("rst_ready", lsu_ready, 1'b1);

    // Single ALU write: visible the cycle after the edge, gone the cycle after that
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("t2_we3", WE3, 1'b1);
    chk("t2_ad3", AD3, 5'd5);
    chk("t2_wd3", WD3, 32'hDEADBEEF);
    idle();
    step();
    chk("t2_we3_off", WE3, 1'b0);

    // ALU keeps priority over a buffered load; busy clears one cycle after its write
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0;
    chk("t3_busy7_set", busy[7], 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h100;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
    step();
    lsu_valid = 1'b0;
    chk("t3_w1", AD3, 5'd3);
    chk("t3_cnt", fifo_count, 3'd1);
    alu_data = 32'h101;
    step();
    chk("t3_w2", WD3, 32'h101);
    alu_data = 32'h102;
    step();
    chk("t3_w3", WD3, 32'h102);
    alu_valid = 1'b0;
    step();
    chk("t3_ld_we", WE3, 1'b1);
    chk("t3_ld_ad", AD3, 5'd7);
    chk("t3_ld_wd", WD3, 32'h11);
    chk("t3_busy7_hold", busy[7], 1'b1);
    step();
    chk("t3_busy7_clr", busy[7], 1'b0);
    chk("t3_idle", WE3, 1'b0);

    // Fill FIFO behind a held ALU stream, stall a 5th offer, then drain in order
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(i); lsu_data = 32'h40 + 32'(i);
      step();
    end
    chk("t4_full_cnt", fifo_count, 3'd4);
    chk("t4_full_rdy", lsu_ready, 1'b0);
    lsu_rd = 5'd5; lsu_data = 32'h55;
    step();
    chk("t4_stall_cnt", fifo_count, 3'd4);
    alu_valid = 1'b0;
    step();
    chk("t4_x1", AD3, 5'd1);
    chk("t4_x1_cnt", fifo_count, 3'd3);
    step();
    lsu_valid = 1'b0;
    chk("t4_x2", AD3, 5'd2);
    chk("t4_5th_in", fifo_count, 3'd3);
    step();
    chk("t4_x3", AD3, 5'd3);
    step();
    chk("t4_x4", WD3, 32'h44);
    step();
    chk("t4_x5", WD3, 32'h55);
    chk("t4_empty", fifo_count, 3'd0);
    step();

    // Scoreboard set-wins, x0 never busy, alu_rd=0 frees the slot for a pop
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    step();
    lsu_valid = 1'b0; alu_valid = 1'b0;
    step();
    chk("t5_pop9", AD3, 5'd9);
    chk("t5_pop9_wd", WD3, 32'h99);
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    chk("t5_busy9_setwins", busy[9], 1'b1);
    iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("t5_busy0", busy[0], 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
    step();
    lsu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'hBAD;
    step();
    chk("t5_x0_pop_ad", AD3, 5'd6);
    chk("t5_x0_pop_wd", WD3, 32'h66);
    idle();
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      step();
    end

    // Reset in the middle of traffic
    rand_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_we3", WE3, 1'b0);
    chk("t1_ad3", AD3, 5'd0);
    chk("t1_wd3", WD3, 32'd0);
    chk("t1_busy", busy, 32'd0);
    chk("t1_cnt", fifo_count, 3'd0);
    chk("t1_ready", lsu_ready, 1'b1);
    idle();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t1_no_write", WE3, 1'b0);

    for (int c = 0; c < 1000; c++) begin
      rand_inputs();
      step();
    end
    idle();
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
